// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 command controller: FSM encoding, device
// response codes, CPU register offsets and STATUS bit positions.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_TX,
    ST_WAIT_RSP,
    ST_NEXT,
    ST_DONE
  } state_t;

  localparam logic [7:0] RSP_ACK    = 8'hFA;
  localparam logic [7:0] RSP_RESEND = 8'hFE;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_ARG    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RSP    = 2'd3;

  localparam int STAT_BUSY    = 7;
  localparam int STAT_TIMEOUT = 6;
  localparam int STAT_TX      = 5;
  localparam int STAT_NACK    = 4;
  localparam int STAT_OVERRUN = 3;

  function automatic logic [7:0] packStatus(input logic busy, input logic tmo,
                                            input logic txErr, input logic nack,
                                            input logic ovr);
    logic [7:0] s;
    s               = '0;
    s[STAT_BUSY]    = busy;
    s[STAT_TIMEOUT] = tmo;
    s[STAT_TX]      = txErr;
    s[STAT_NACK]    = nack;
    s[STAT_OVERRUN] = ovr;
    return s;
  endfunction

endpackage

// File: rtl/ps2_timeout_cnt.sv
// Saturating cycle counter with a synchronous load-to-zero, used to time out
// the transmitter and device-response waits.
module ps2_timeout_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= '0;
    end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ps2_cmd_ctrl.sv
// PS/2 host command controller: CPU register interface, command/argument send
// sequencing with ack/resend handling and timeouts. PS2_RETRY_EN enables resends.
module ps2_cmd_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000000,
  parameter int MAX_RETRY   = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_request,
  input  logic        i_write,
  input  logic [11:0] i_address,
  input  logic [7:0]  i_data,
  output logic [7:0]  o_data,
  output logic        o_data_DV,
  output logic [7:0]  o_tx_byte,
  output logic        o_tx_start,
  input  logic        i_tx_done,
  input  logic        i_tx_err,
  input  logic [7:0]  i_rx_byte,
  input  logic        i_rx_valid,
  output logic [7:0]  o_rx_byte,
  output logic        o_rx_valid,
  output logic        o_busy
);

  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t state_q, state_d;
  logic [7:0] cmd_q, cmd_d, arg_q, arg_d, curByte_q, curByte_d, lastRsp_q, lastRsp_d;
  logic [7:0] data_q, data_d, rxByte_q, rxByte_d;
  logic argPend_q, argPend_d, argSent_q, argSent_d;
  logic errTimeout_q, errTimeout_d, errTx_q, errTx_d, errNack_q, errNack_d;
  logic overrun_q, overrun_d, dataDv_q, dataDv_d, rxValid_q, rxValid_d;
  logic [TW-1:0] toCount;
  logic [1:0] regOff;
  logic timeUp, isProto, unusedAddr;

`ifdef PS2_RETRY_EN
  localparam int RW = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
  logic [RW-1:0] retry_q, retry_d;
`else
  localparam int unusedRetry = MAX_RETRY;
`endif

  assign regOff     = i_address[1:0];
  assign unusedAddr = ^i_address[11:2];
  assign timeUp     = (toCount == TO_LAST);
  assign isProto    = (i_rx_byte == RSP_ACK) || (i_rx_byte == RSP_RESEND);

  // Restarts on every state change so each wait gets a fresh budget.
  ps2_timeout_cnt #(.WIDTH(TW)) u_timeout (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .load_i (state_d != state_q),
    .en_i   ((state_q == ST_WAIT_TX) || (state_q == ST_WAIT_RSP)),
    .count_o(toCount)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      arg_q        <= '0;
      curByte_q    <= '0;
      lastRsp_q    <= '0;
      data_q       <= '0;
      rxByte_q     <= '0;
      argPend_q    <= 1'b0;
      argSent_q    <= 1'b0;
      errTimeout_q <= 1'b0;
      errTx_q      <= 1'b0;
      errNack_q    <= 1'b0;
      overrun_q    <= 1'b0;
      dataDv_q     <= 1'b0;
      rxValid_q    <= 1'b0;
`ifdef PS2_RETRY_EN
      retry_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      arg_q        <= arg_d;
      curByte_q    <= curByte_d;
      lastRsp_q    <= lastRsp_d;
      data_q       <= data_d;
      rxByte_q     <= rxByte_d;
      argPend_q    <= argPend_d;
      argSent_q    <= argSent_d;
      errTimeout_q <= errTimeout_d;
      errTx_q      <= errTx_d;
      errNack_q    <= errNack_d;
      overrun_q    <= overrun_d;
      dataDv_q     <= dataDv_d;
      rxValid_q    <= rxValid_d;
`ifdef PS2_RETRY_EN
      retry_q      <= retry_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    arg_d        = arg_q;
    curByte_d    = curByte_q;
    lastRsp_d    = lastRsp_q;
    data_d       = data_q;
    rxByte_d     = rxByte_q;
    argPend_d    = argPend_q;
    argSent_d    = argSent_q;
    errTimeout_d = errTimeout_q;
    errTx_d      = errTx_q;
    errNack_d    = errNack_q;
    overrun_d    = overrun_q;
    dataDv_d     = 1'b0;
    rxValid_d    = 1'b0;
`ifdef PS2_RETRY_EN
    retry_d      = retry_q;
`endif

    // Reads sample the pre-edge registers, so STATUS reflects the old state.
    if (i_request) begin
      dataDv_d = 1'b1;
      data_d   = '0;
      if (!i_write) begin
        case (regOff)
          REG_CMD:    data_d = cmd_q;
          REG_ARG:    data_d = arg_q;
          REG_STATUS: begin
            data_d    = packStatus(state_q != ST_IDLE, errTimeout_q, errTx_q,
                                   errNack_q, overrun_q);
            overrun_d = 1'b0;
          end
          default:    data_d = lastRsp_q;
        endcase
      end else if ((regOff == REG_CMD) || (regOff == REG_ARG)) begin
        if (state_q != ST_IDLE) begin
          overrun_d = 1'b1;
        end else if (regOff == REG_CMD) begin
          cmd_d        = i_data;
          curByte_d    = i_data;
          errTimeout_d = 1'b0;
          errTx_d      = 1'b0;
          errNack_d    = 1'b0;
          argSent_d    = 1'b0;
`ifdef PS2_RETRY_EN
          retry_d      = '0;
`endif
          state_d      = ST_SEND;
        end else begin
          arg_d     = i_data;
          argPend_d = 1'b1;
        end
      end
    end

    if (i_rx_valid && !((state_q == ST_WAIT_RSP) && isProto)) begin
      rxByte_d  = i_rx_byte;
      rxValid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: ;
      ST_SEND: state_d = ST_WAIT_TX;
      ST_WAIT_TX: begin
        if (i_tx_done) begin
          state_d = ST_WAIT_RSP;
        end else if (i_tx_err) begin
          errTx_d = 1'b1;
          state_d = ST_DONE;
        end else if (timeUp) begin
          errTimeout_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_WAIT_RSP: begin
        if (i_rx_valid && (i_rx_byte == RSP_ACK)) begin
          lastRsp_d = i_rx_byte;
          state_d   = ST_NEXT;
        end else if (i_rx_valid && (i_rx_byte == RSP_RESEND)) begin
          lastRsp_d = i_rx_byte;
`ifdef PS2_RETRY_EN
          if (retry_q < RETRY_LIM) begin
            retry_d = retry_q + 1'b1;
            state_d = ST_SEND;
          end else begin
            errNack_d = 1'b1;
            state_d   = ST_DONE;
          end
`else
          errNack_d = 1'b1;
          state_d   = ST_DONE;
`endif
        end else if (timeUp) begin
          errTimeout_d = 1'b1;
          state_d      = ST_DONE;
        end
      end
      ST_NEXT: begin
        if (argPend_q && !argSent_q) begin
          curByte_d = arg_q;
          argSent_d = 1'b1;
`ifdef PS2_RETRY_EN
          retry_d   = '0;
`endif
          state_d   = ST_SEND;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        argPend_d = 1'b0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign o_busy     = (state_q != ST_IDLE);
  assign o_tx_start = (state_q == ST_SEND);
  assign o_tx_byte  = curByte_q;
  assign o_data     = data_q;
  assign o_data_DV  = dataDv_q;
  assign o_rx_byte  = rxByte_q;
  assign o_rx_valid = rxValid_q;

endmodule
